hwjsoc_cpu_oci_trace_capture: RTL
=================================

// Module: hwjsoc_cpu_oci_trace_capture
// PURPOSE
//  Parametrised debug-capture-trace (DCT) buffer for the CPU OCI test path.
//  Captures DCT words from the OCI into a circular buffer until the test ends,
//  then drains them in order over a valid/ready stream to the sim/debug host.
//  Reports occupancy, sticky overflow and end-of-test status.
// PARAMETERS
//  DATA_W    30  width of one DCT word
//  ADDR_W    4   buffer address width; DEPTH = 2**ADDR_W (default 16)
//  WRAP_MODE 0   0 = drop writes when full; 1 = overwrite oldest when full
// PORTS
//  clk             in   1         single clock, all logic rising-edge
//  reset           in   1         synchronous, active-high
//  dct_valid       in   1         dct_buffer holds a word to capture this cycle
//  dct_buffer      in   DATA_W    DCT word
//  test_ending     in   1         pulse: stop capture, begin drain
//  out_ready       in   1         consumer accepts out_data this cycle
//  out_valid       out  1         out_data valid
//  out_data        out  DATA_W    oldest buffered word (first-word-fall-through)
//  dct_count       out  ADDR_W+1  words currently buffered, 0..DEPTH
//  overflow        out  1         sticky: a write arrived while full
//  test_has_ended  out  1         drain complete; held until reset
// BEHAVIOUR
//  Reset: all outputs 0, rd/wr pointers 0, FSM = CAPTURE. Buffer contents
//   need not be cleared. Reset in any state (incl. mid-drain) aborts to this.
//  FSM: CAPTURE -> DRAIN -> DONE.
//  CAPTURE: out_valid=0. dct_valid=1 writes mem[wr_ptr], wr_ptr++, count++.
//   Full (count==DEPTH) + dct_valid:
//    WRAP_MODE=0: word dropped, pointers/count unchanged, overflow<=1.
//    WRAP_MODE=1: mem[wr_ptr] overwritten, wr_ptr++ and rd_ptr++, count
//     stays DEPTH, overflow<=1.
//   test_ending=1: next state DRAIN. A dct_valid in the same cycle is
//    still captured (full rules apply).
//  DRAIN: dct_valid ignored (no write, no overflow). out_valid = (count!=0).
//   out_data = mem[rd_ptr], combinational from pointer; 0 when out_valid=0.
//   Pop on out_valid&&out_ready: rd_ptr++, count--. out_valid/out_data may
//   not change while out_valid=1 and out_ready=0.
//   Next state DONE when count==0, or count==1 with a pop this cycle.
//   DRAIN always lasts >=1 cycle (empty buffer: 1 cycle).
//  DONE: out_valid=0, test_has_ended=1 (registered, asserts on the cycle
//   DONE is entered), dct_valid/test_ending/out_ready ignored until reset.
//  test_ending in DRAIN/DONE: ignored.
//  Pointers wrap modulo DEPTH naturally (ADDR_W bits); count is ADDR_W+1
//   bits so DEPTH is representable. Throughput: 1 write/cycle in CAPTURE,
//   1 pop/cycle in DRAIN.
//  dct_count and overflow are registered; visible the cycle after the event.
// TESTING (DATA_W=30, ADDR_W=4 unless stated)
//  1 reset held 2 cycles -> dct_count=0, out_valid=0, overflow=0,
//    test_has_ended=0; assert reset mid-drain -> same values next cycle.
//  2 write 0x1..0x5, pulse test_ending, out_ready=1 -> out_data 0x1..0x5 on
//    5 consecutive cycles from first DRAIN cycle; test_has_ended=1 next cycle.
//  3 WRAP_MODE=0: write 0..19 -> dct_count=16, overflow=1; drain yields 0..15.
//  4 WRAP_MODE=1: write 0..19 -> dct_count=16, overflow=1; drain yields 4..19.
//  5 test_ending with empty buffer -> out_valid stays 0, DRAIN 1 cycle,
//    test_has_ended=1 two cycles after pulse.
//  6 write 0xA..0xD, test_ending together with dct_valid(0xE); out_ready
//    toggled 1,0,0,1,... -> 0xA..0xE in order, data stable while stalled,
//    dct_valid during DRAIN not captured.

Source files
------------

// File: rtl/hwjsoc_cpu_oci_trace_capture_if.sv
// Capture/drain stream bundle for the OCI debug-capture-trace buffer.
// The master side feeds DCT words and consumes the drained stream; the slave side is the buffer.
interface hwjsoc_cpu_oci_trace_capture_if #(
  parameter int DATA_W = 30,
  parameter int ADDR_W = 4
);
  logic              dct_valid;
  logic [DATA_W-1:0] dct_buffer;
  logic              test_ending;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   dct_count;
  logic              overflow;
  logic              test_has_ended;

  modport master (
    output dct_valid, dct_buffer, test_ending, out_ready,
    input  out_valid, out_data, dct_count, overflow, test_has_ended
  );

  modport slave (
    input  dct_valid, dct_buffer, test_ending, out_ready,
    output out_valid, out_data, dct_count, overflow, test_has_ended
  );
endinterface

// File: rtl/hwjsoc_cpu_oci_trace_capture.sv
// Circular DCT capture buffer: records words until the test ends, then drains
// them oldest-first over a first-word-fall-through valid/ready stream.
module hwjsoc_cpu_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int ADDR_W    = 4,
  parameter int WRAP_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  hwjsoc_cpu_oci_trace_capture_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   ZERO_CNT = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r, ended_r;
  logic              full_s, wr_en_s, rd_adv_s, cnt_inc_s, cnt_dec_s, ovf_set_s;
  logic              out_valid_s, pop_s;

  assign full_s = (count_r == FULL_CNT);

  // Next-state and per-cycle buffer actions; a full wrapping write advances both pointers.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    rd_adv_s    = 1'b0;
    cnt_inc_s   = 1'b0;
    cnt_dec_s   = 1'b0;
    ovf_set_s   = 1'b0;
    out_valid_s = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_CAPTURE: begin
        if (bus.dct_valid) begin
          if (full_s) begin
            ovf_set_s = 1'b1;
            if (WRAP_MODE != 0) begin
              wr_en_s  = 1'b1;
              rd_adv_s = 1'b1;
            end else begin
              wr_en_s  = 1'b0;
            end
          end else begin
            wr_en_s   = 1'b1;
            cnt_inc_s = 1'b1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
        if (bus.test_ending) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        out_valid_s = (count_r != ZERO_CNT);
        pop_s       = out_valid_s & bus.out_ready;
        rd_adv_s    = pop_s;
        cnt_dec_s   = pop_s;
        if ((count_r == ZERO_CNT) || ((count_r == ONE_CNT) && pop_s)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_CAPTURE;
      end
    endcase
  end

  // State, pointers, occupancy and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_CAPTURE;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= ZERO_CNT;
      overflow_r <= 1'b0;
      ended_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (cnt_inc_s) begin
        count_r <= count_r + ONE_CNT;
      end else if (cnt_dec_s) begin
        count_r <= count_r - ONE_CNT;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (state_nxt_s == ST_DONE) begin
        ended_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.dct_buffer;
    end
  end

  assign bus.out_valid      = out_valid_s;
  assign bus.out_data       = out_valid_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign bus.dct_count      = count_r;
  assign bus.overflow       = overflow_r;
  assign bus.test_has_ended = ended_r;

endmodule
